fifo_uart_tx: RTL and testbench

// Downstream drain stage for the byte FIFO: pops one byte whenever the FIFO is non-empty and
// the block is idle, then shifts it out as an asynchronous serial frame on a single line
// (start bit, 8 data bits LSB first, optional parity, stop bit). The FIFO read is modelled as a
// pop strobe with one-cycle registered data return, matching the FIFO's registered data_out.

---
 rtl/fifo_uart_tx.sv | 188 ++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a byte FIFO and transmits each byte as an asynchronous
// serial frame: start bit, 8 data bits LSB first, optional even parity, stop bit(s).
// The FIFO read is a one-cycle pop strobe. Read data is expected on the following cycle.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    STOP   = 3'd6
  } state_t;
`endif

  localparam logic [15:0] CNT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] CNT_PRE   = 16'(CLKS_PER_BIT - 2);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  state_t      state_r;
  logic [15:0] cnt_r;
  logic [2:0]  idx_r;
  logic [7:0]  shift_r;
`ifdef UART_TX_PARITY_EN
  logic        parity_r;
`endif

  logic start_ok_s;
  logic cnt_end_s;
  logic stop_last_s;
  logic stop_pre_s;

  // Decode of frame-start permission and bit-timing boundaries.
  always_comb begin
    start_ok_s  = tx_en & ~fifo_empty;
    cnt_end_s   = (cnt_r == CNT_LAST);
    stop_last_s = cnt_end_s && (idx_r == STOP_LAST);
    stop_pre_s  = (cnt_r == CNT_PRE) && (idx_r == STOP_LAST);
  end

  // Frame sequencer. Outputs are registered and take their next-cycle value on each transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 16'd0;
      idx_r      <= 3'd0;
      shift_r    <= 8'd0;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
      fifo_rd    <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fifo_rd    <= 1'b0;
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          tx <= 1'b1;
          if (start_ok_s) begin
            state_r <= POP;
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        POP: begin
          state_r <= LOAD;
        end
        LOAD: begin
          shift_r  <= fifo_data;
`ifdef UART_TX_PARITY_EN
          parity_r <= even_parity(fifo_data);
`endif
          cnt_r    <= 16'd0;
          tx       <= 1'b0;
          state_r  <= START;
        end
        START: begin
          if (cnt_end_s) begin
            cnt_r   <= 16'd0;
            idx_r   <= 3'd0;
            tx      <= shift_r[0];
            state_r <= DATA;
          end else begin
            cnt_r   <= cnt_r + 16'd1;
          end
        end
        DATA: begin
          if (cnt_end_s) begin
            cnt_r   <= 16'd0;
            shift_r <= {1'b0, shift_r[7:1]};
            if (idx_r == 3'd7) begin
              idx_r   <= 3'd0;
`ifdef UART_TX_PARITY_EN
              tx      <= parity_r;
              state_r <= PARITY;
`else
              tx      <= 1'b1;
              state_r <= STOP;
`endif
            end else begin
              idx_r   <= idx_r + 3'd1;
              tx      <= shift_r[1];
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (cnt_end_s) begin
            cnt_r   <= 16'd0;
            idx_r   <= 3'd0;
            tx      <= 1'b1;
            state_r <= STOP;
          end else begin
            cnt_r   <= cnt_r + 16'd1;
          end
        end
`endif
        STOP: begin
          tx <= 1'b1;
          if (stop_pre_s) begin
            frame_done <= 1'b1;
          end
          if (stop_last_s) begin
            cnt_r <= 16'd0;
            idx_r <= 3'd0;
            if (start_ok_s) begin
              state_r <= POP;
              fifo_rd <= 1'b1;
              busy    <= 1'b1;
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else if (cnt_end_s) begin
            cnt_r <= 16'd0;
            idx_r <= idx_r + 3'd1;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= 16'd0;
          idx_r      <= 3'd0;
          tx         <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx. A queue-based FIFO environment feeds the DUT, and a
// frame-level reference model predicts tx, busy, fifo_rd and frame_done on every cycle.
module tb_fifo_uart_tx;

  localparam int C  = 4;
  localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 9 + PAR + SB;   // start + data + parity + stop bits
  localparam int L  = 2 + NB * C;     // POP + LOAD + serial bits

  logic       clk;
  logic       rst_n;
  logic       tx_en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       frame_done;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(SB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] fifo_q[$];   // environment FIFO contents
  logic [7:0] ref_q[$];    // reference model copy of the pushed bytes

  int          m_pos = -1; // position within the current frame, -1 = idle
  logic [15:0] m_bits;     // serial bits of the current frame, index 0 sent first

  int rd_cnt, fd_cnt, busy_cnt, cyc, first_fd_cyc, last_rd_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    if (m_pos < 2) return 1'b1;
    return m_bits[(m_pos - 2) / C];
  endfunction

  task automatic build_frame(input logic [7:0] b);
    m_bits = 16'hFFFF;
    m_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) m_bits[1 + i] = b[i];
    if (PAR == 1) m_bits[9] = ^b;
  endtask

  task automatic reset_counts();
    rd_cnt = 0; fd_cnt = 0; busy_cnt = 0;
    first_fd_cyc = -1; last_rd_cyc = -1;
  endtask

  // One clock cycle: compare outputs, serve the FIFO, apply inputs, advance the model.
  task automatic cycle(input logic do_push, input logic [7:0] b, input logic en);
    @(negedge clk);
    cyc++;
    check_eq("tx",         32'(tx),         32'(exp_tx()));
    check_eq("busy",       32'(busy),       32'(m_pos >= 0));
    check_eq("fifo_rd",    32'(fifo_rd),    32'(m_pos == 0));
    check_eq("frame_done", 32'(frame_done), 32'(m_pos == L - 1));
    if (fifo_rd === 1'b1) begin
      rd_cnt++;
      last_rd_cyc = cyc;
      if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      if (first_fd_cyc < 0) first_fd_cyc = cyc;
    end
    if (busy === 1'b1) busy_cnt++;
    if (do_push) begin
      fifo_q.push_back(b);
      ref_q.push_back(b);
    end
    tx_en      = en;
    fifo_empty = (fifo_q.size() == 0);
    if (m_pos == -1 || m_pos == L - 1) begin
      if (tx_en && !fifo_empty && ref_q.size() > 0) begin
        m_pos = 0;
        build_frame(ref_q.pop_front());
      end else begin
        m_pos = -1;
      end
    end else begin
      m_pos++;
    end
  endtask

  initial begin
    int guard;
    logic en_r;
    rst_n = 1'b0; tx_en = 1'b0; fifo_empty = 1'b1; fifo_data = 8'd0; cyc = 0;
    reset_counts();
    repeat (3) @(negedge clk);
    check_eq("rst_tx",   32'(tx),         32'd1);
    check_eq("rst_busy", 32'(busy),       32'd0);
    check_eq("rst_rd",   32'(fifo_rd),    32'd0);
    check_eq("rst_fd",   32'(frame_done), 32'd0);
    rst_n = 1'b1;

    // Single byte 0x55
    reset_counts();
    cycle(1'b1, 8'h55, 1'b1);
    repeat (L + 15) cycle(1'b0, 8'h00, 1'b1);
    check_eq("single_rd_pulses", 32'(rd_cnt),   32'd1);
    check_eq("single_fd_pulses", 32'(fd_cnt),   32'd1);
    check_eq("single_busy_len",  32'(busy_cnt), 32'(L));

    // Back-to-back 0x00, 0xFF
    reset_counts();
    cycle(1'b1, 8'h00, 1'b1);
    cycle(1'b1, 8'hFF, 1'b1);
    repeat (2 * L + 15) cycle(1'b0, 8'h00, 1'b1);
    check_eq("b2b_rd_pulses", 32'(rd_cnt), 32'd2);
    check_eq("b2b_fd_pulses", 32'(fd_cnt), 32'd2);
    check_eq("b2b_gap",       32'(last_rd_cyc - first_fd_cyc), 32'd1);

    // Empty FIFO for 100 cycles
    reset_counts();
    repeat (100) cycle(1'b0, 8'h00, 1'b1);
    check_eq("empty_rd",   32'(rd_cnt),   32'd0);
    check_eq("empty_busy", 32'(busy_cnt), 32'd0);

    // tx_en dropped during DATA of 0x3C, second byte waits
    reset_counts();
    cycle(1'b1, 8'h3C, 1'b1);
    cycle(1'b1, 8'h5A, 1'b1);
    guard = 0;
    while (m_pos != 2 + 3 * C && guard < 200) begin
      cycle(1'b0, 8'h00, 1'b1);
      guard++;
    end
    check_eq("txen_reach_data", 32'(m_pos), 32'(2 + 3 * C));
    repeat (L + 20) cycle(1'b0, 8'h00, 1'b0);
    check_eq("txen_hold_rd", 32'(rd_cnt), 32'd1);
    check_eq("txen_hold_fd", 32'(fd_cnt), 32'd1);
    repeat (L + 10) cycle(1'b0, 8'h00, 1'b1);
    check_eq("txen_resume_rd", 32'(rd_cnt), 32'd2);

    // Parity-sensitive bytes (parity bit checked by the model when enabled)
    reset_counts();
    cycle(1'b1, 8'h07, 1'b1);
    cycle(1'b1, 8'h03, 1'b1);
    repeat (2 * L + 10) cycle(1'b0, 8'h00, 1'b1);
    check_eq("par_rd_pulses", 32'(rd_cnt), 32'd2);

    // Randomized pushes and tx_en toggling
    en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) en_r = ~en_r;
      cycle(($urandom_range(0, 39) == 0), 8'($urandom), en_r);
    end

    // Drain, then reset in the middle of DATA of 0xA5
    guard = 0;
    while ((m_pos != -1 || ref_q.size() != 0) && guard < 5000) begin
      cycle(1'b0, 8'h00, 1'b1);
      guard++;
    end
    check_eq("drain_done", 32'(ref_q.size()), 32'd0);
    cycle(1'b1, 8'hA5, 1'b1);
    guard = 0;
    while (m_pos != 2 + 3 * C && guard < 200) begin
      cycle(1'b0, 8'h00, 1'b1);
      guard++;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_tx",   32'(tx),      32'd1);
    check_eq("midrst_busy", 32'(busy),    32'd0);
    check_eq("midrst_rd",   32'(fifo_rd), 32'd0);
    m_pos = -1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    reset_counts();
    repeat (20) cycle(1'b0, 8'h00, 1'b1);
    check_eq("postrst_rd",   32'(rd_cnt),   32'd0);
    check_eq("postrst_busy", 32'(busy_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
